// File: rtl/uart_pkg.sv
// uart_pkg: frame constants and receiver state type shared by the UART transmitter, receiver and controller.
package uart_pkg;
   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous input pins; both stages reset to 1, which is the idle level of the line.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_meta <= '1;
         r_q    <= '1;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   assign o_q = r_q;
endmodule

// File: rtl/uart_rx_mv.sv
// uart_rx_mv: 8N1 UART receiver that decides each bit by a 2-of-3 vote around the bit centre.
// It flags framing errors and line breaks, and returns to IDLE at the stop-bit centre so frames can arrive back-to-back.
module uart_rx_mv
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_serial_line,
   output logic                      rx_ready,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      frame_err,
   output logic                      break_det,
   output logic                      busy
);
   localparam int H  = CLK_PER_BIT / 2;
   localparam int CW = $clog2(CLK_PER_BIT) + 1;
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
   logic                      w_s;
   logic                      w_dec;
   logic                      w_maj;
   logic                      w_ready;
   logic                      w_ferr;
   logic                      w_brk;
   uart_state_t               r_state;
   uart_state_t               w_next;
   logic [CW-1:0]             r_cnt;
   logic [3:0]                r_idx;
   logic [1:0]                r_smp;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] r_data;
   logic                      r_ready;
   logic                      r_ferr;
   logic                      r_brk;
   logic                      r_busy;
   sync2 #(.WIDTH(1)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .i_d  (rx_serial_line),
      .o_q  (w_s)
   );
   // The third sample is the live line, so the vote settles on the cycle of the last sample.
   assign w_dec = (r_cnt == CW'(H + 1));
   assign w_maj = maj3(r_smp[0], r_smp[1], w_s);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_ferr  = 1'b0;
      w_brk   = 1'b0;
      case (r_state)
         IDLE:      w_next = w_s ? IDLE : START;
         START:     w_next = w_dec ? (w_maj ? IDLE : DATA) : START;
         DATA:      w_next = (w_dec && r_idx == 4'(UART_FRAME_BITS - 2)) ? STOP : DATA;
         STOP: begin
            w_next  = w_dec ? (w_maj ? IDLE : WAIT_HIGH) : STOP;
            w_ready = w_dec && w_maj;
            w_ferr  = w_dec && !w_maj;
            w_brk   = w_dec && !w_maj && (r_shift == '0);
         end
         WAIT_HIGH: w_next = w_s ? IDLE : WAIT_HIGH;
         default:   w_next = IDLE;
      endcase
   end
   // In IDLE the counter already holds the offset of the next cycle, so the start edge lands on cycle 0.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_smp   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_ready <= 1'b0;
         r_ferr  <= 1'b0;
         r_brk   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_cnt   <= (r_state == IDLE) ? CW'(!w_s) : (r_cnt == CW'(CLK_PER_BIT - 1)) ? '0 : r_cnt + CW'(1);
         r_idx   <= (r_state == IDLE) ? 4'd0 : (r_cnt == CW'(CLK_PER_BIT - 1)) ? r_idx + 4'd1 : r_idx;
         if (r_cnt == CW'(H - 1)) r_smp[0] <= w_s;
         if (r_cnt == CW'(H)) r_smp[1] <= w_s;
         if (r_state == DATA && w_dec) r_shift <= {w_maj, r_shift[UART_DATA_BITS-1:1]};
         if (w_ready) r_data <= r_shift;
         r_ready <= w_ready;
         r_ferr  <= w_ferr;
         r_brk   <= w_brk;
         r_busy  <= (w_next != IDLE);
      end
   assign rx_ready  = r_ready;
   assign rx_data   = r_data;
   assign frame_err = r_ferr;
   assign break_det = r_brk;
   assign busy      = r_busy;
endmodule
